// File: rtl/pia_fifo.sv
// Keyboard/display character FIFOs behind a 4-byte CPU register window.
// Both peripheral sides use 4-phase handshakes; asynchronous handshake inputs are double-flopped.

module pia_fifo_buf #(
  parameter int DEPTH = 4,
  parameter int DW    = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [DW-1:0]            din_i,
  output logic [DW-1:0]            dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rptr_q];

  // Push on full and pop on empty are silently ignored.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end
endmodule

// State table
//   K_IDLE | waiting for kbd_rdy with room in KFIFO
//   K_ACK  | character taken, kbd_ack high until kbd_rdy drops
//   D_IDLE | waiting for a queued character and dsp_ack low
//   D_REQ  | dsp_rdy high, dsp_data holds the head character
//   D_WAIT | character consumed, waiting for dsp_ack to drop
module pia_fifo #(
  parameter logic [15:0] BASE_ADDR = 16'hD010,
  parameter int          DEPTH     = 4,
  parameter int          DW        = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [15:0]   AB,
  input  logic          WE,
  input  logic [7:0]    DI,
  output logic [7:0]    DO,
  output logic          irq,
  input  logic          kbd_rdy,
  output logic          kbd_ack,
  input  logic [DW-1:0] kbd_data,
  output logic          dsp_rdy,
  input  logic          dsp_ack,
  output logic [DW-1:0] dsp_data
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic {K_IDLE, K_ACK} kstate_e;
  typedef enum logic [1:0] {D_IDLE, D_REQ, D_WAIT} dstate_e;

  kstate_e       kstate_q, kstate_d;
  dstate_e       dstate_q, dstate_d;
  logic          kbd_rdy_s1_q, kbd_rdy_s2_q;
  logic          dsp_ack_s1_q, dsp_ack_s2_q;
  logic [7:0]    do_q, do_d;
  logic          ovf_q, ovf_d;
  logic          ien_q, ien_d;
  logic [DW-1:0] dsp_data_q, dsp_data_d;

  logic [15:0]   win_off;
  logic          in_win, cpu_rd, cpu_wr;
  logic [1:0]    sel;
  logic [7:0]    rd_data, ctl_byte;
  logic [6:0]    k_head7, d_count7;

  logic          k_push, k_pop, k_full, k_empty;
  logic [DW-1:0] k_head;
  logic [CW-1:0] k_count;
  logic          d_push, d_pop, d_full, d_empty;
  logic [DW-1:0] d_head;
  logic [CW-1:0] d_count;
  logic          unused_di;

  assign unused_di = ^DI[7:DW];

  // Unsigned offset makes addresses below the base wrap far outside the window.
  assign win_off = AB - BASE_ADDR;
  assign in_win  = (win_off < 16'd4);
  assign sel     = win_off[1:0];
  assign cpu_rd  = in_win & ~WE;
  assign cpu_wr  = in_win & WE;

  pia_fifo_buf #(.DEPTH(DEPTH), .DW(DW)) u_kfifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (k_push),
    .pop_i   (k_pop),
    .din_i   (kbd_data),
    .dout_o  (k_head),
    .count_o (k_count),
    .full_o  (k_full),
    .empty_o (k_empty)
  );

  pia_fifo_buf #(.DEPTH(DEPTH), .DW(DW)) u_dfifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (d_push),
    .pop_i   (d_pop),
    .din_i   (DI[DW-1:0]),
    .dout_o  (d_head),
    .count_o (d_count),
    .full_o  (d_full),
    .empty_o (d_empty)
  );

  always_comb begin
    k_head7             = '0;
    k_head7[DW-1:0]     = k_head;
    d_count7            = '0;
    d_count7[CW-1:0]    = d_count;
    ctl_byte            = {~k_empty, 4'b0000, ovf_q, ien_q, k_full};
    case (sel)
      2'd0:    rd_data = k_empty ? 8'h00 : {1'b1, k_head7};
      2'd2:    rd_data = {d_full, d_count7};
      default: rd_data = ctl_byte;
    endcase
  end

  assign do_d   = cpu_rd ? rd_data : 8'h00;
  assign k_pop  = cpu_rd & (sel == 2'd0) & ~k_empty;
  assign d_push = cpu_wr & (sel == 2'd2);

  always_comb begin
    ovf_d = ovf_q;
    ien_d = ien_q;
    if (d_push && d_full)                ovf_d = 1'b1;
    else if (cpu_rd && (sel == 2'd1))    ovf_d = 1'b0;
    if (cpu_wr && (sel == 2'd3))         ien_d = DI[0];
  end

  always_comb begin
    kstate_d = kstate_q;
    k_push   = 1'b0;
    case (kstate_q)
      K_IDLE: if (kbd_rdy_s2_q && !k_full) begin
        kstate_d = K_ACK;
        k_push   = 1'b1;
      end
      K_ACK:  if (!kbd_rdy_s2_q) kstate_d = K_IDLE;
      default: kstate_d = K_IDLE;
    endcase
  end

  always_comb begin
    dstate_d   = dstate_q;
    dsp_data_d = dsp_data_q;
    d_pop      = 1'b0;
    case (dstate_q)
      D_IDLE: if (!d_empty && !dsp_ack_s2_q) begin
        dstate_d   = D_REQ;
        dsp_data_d = d_head;
      end
      D_REQ:  if (dsp_ack_s2_q) begin
        dstate_d = D_WAIT;
        d_pop    = 1'b1;
      end
      D_WAIT: if (!dsp_ack_s2_q) dstate_d = D_IDLE;
      default: dstate_d = D_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kbd_rdy_s1_q <= 1'b0;
      kbd_rdy_s2_q <= 1'b0;
      dsp_ack_s1_q <= 1'b0;
      dsp_ack_s2_q <= 1'b0;
      kstate_q     <= K_IDLE;
      dstate_q     <= D_IDLE;
      do_q         <= 8'h00;
      ovf_q        <= 1'b0;
      ien_q        <= 1'b0;
      dsp_data_q   <= '0;
    end else begin
      kbd_rdy_s1_q <= kbd_rdy;
      kbd_rdy_s2_q <= kbd_rdy_s1_q;
      dsp_ack_s1_q <= dsp_ack;
      dsp_ack_s2_q <= dsp_ack_s1_q;
      kstate_q     <= kstate_d;
      dstate_q     <= dstate_d;
      do_q         <= do_d;
      ovf_q        <= ovf_d;
      ien_q        <= ien_d;
      dsp_data_q   <= dsp_data_d;
    end
  end

  assign DO       = do_q;
  assign irq      = ien_q & ~k_empty;
  assign kbd_ack  = (kstate_q == K_ACK);
  assign dsp_rdy  = (dstate_q == D_REQ);
  assign dsp_data = dsp_data_q;
endmodule

// File: doc/pia_fifo.md
PIA_FIFO -- requirements
Module: pia_fifo

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'hD010, giving the base of a 4-byte register window (offsets 0..3).
REQ-002 SHALL have parameter DEPTH, default 4, giving entries per FIFO; legal values are powers of 2 from 2 to 16.
REQ-003 SHALL have parameter DW, default 7, giving the character width in bits (1..7).
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have the following ports:
  clk  in  1  CPU clock, all state on rising edge
  reset  in  1  asynchronous, active-low reset
  AB  in  16  CPU address bus
  WE  in  1  CPU write enable, 1 = write
  DI  in  8  CPU write data
  DO  out  8  registered read data for the address presented on the previous cycle
  irq  out  1  active-high interrupt request
  kbd_rdy  in  1  keyboard character valid (asynchronous, 4-phase)
  kbd_ack  out  1  keyboard acknowledge
  kbd_data  in  DW  keyboard ASCII
  dsp_rdy  out  1  display character valid (4-phase)
  dsp_ack  in  1  display acknowledge (asynchronous)
  dsp_data  out  DW  display ASCII

Function
REQ-006 SHALL synchronise kbd_rdy and dsp_ack through two flops each before use; all handshake timing below refers to the synchronised values.
REQ-007 SHALL contain two FIFOs, KFIFO and DFIFO, each DEPTH x DW, with a count of width clog2(DEPTH)+1 and wrapping read/write pointers.
REQ-008 SHALL define the register map (sel = AB - BASE_ADDR when AB is inside the window):
  0 KBD  read -> {1, KFIFO head} when non-empty, 8'h00 when empty.
  1 KCTL  read -> {nonempty, 4'b0, ovf, ien, full_k}.
  2 DSP  write -> push DI[DW-1:0] to DFIFO; read -> {full_d, count_d zero-extended to 7 bits}.
  3 DCTL  write -> ien <= DI[0]; read -> same format as KCTL.
REQ-009 SHALL update DO on every rising edge to the read value at AB when AB is in the window and WE=0; otherwise DO SHALL be 8'h00.
REQ-010 SHALL pop KFIFO on the same edge that a KBD read is captured into DO, and only when KFIFO is non-empty.
REQ-011 SHALL treat a DFIFO push while DFIFO is full as a dropped write and set the sticky flag ovf, which is cleared by a KCTL read.
REQ-012 SHALL run the keyboard FSM with states K_IDLE and K_ACK:
  K_IDLE -> K_ACK when kbd_rdy=1 and KFIFO is not full; push kbd_data on that edge and set kbd_ack=1.
  K_ACK -> K_IDLE when kbd_rdy=0; clear kbd_ack on that edge.
  While KFIFO is full, the FSM SHALL stay in K_IDLE with kbd_ack=0 (back-pressure).
REQ-013 SHALL run the display FSM with states D_IDLE, D_REQ and D_WAIT:
  D_IDLE -> D_REQ when DFIFO is non-empty and dsp_ack=0; load dsp_data with the head and set dsp_rdy=1.
  D_REQ -> D_WAIT when dsp_ack=1; pop DFIFO and clear dsp_rdy.
  D_WAIT -> D_IDLE when dsp_ack=0.
REQ-014 SHALL hold dsp_data stable while dsp_rdy=1.
REQ-015 SHALL, when a push and a pop hit the same FIFO on the same edge, perform both and leave the count unchanged; push on full and pop on empty SHALL each be a no-op.
REQ-016 SHALL drive irq = ien AND KFIFO non-empty, as a combinational function of registers.
REQ-017 SHALL ignore writes to offsets 0 and 1 and all accesses outside the window.

Reset
REQ-018 SHALL, while reset=0, set both FIFOs empty with pointers at 0, ovf=0, ien=0, and DO, kbd_ack, dsp_rdy, dsp_data and irq all 0.
REQ-019 SHALL place both FSMs in their IDLE states and clear the synchroniser flops on reset.
REQ-020 SHALL, if reset is asserted mid-handshake, discard any pending characters; after release a still-high kbd_rdy SHALL be accepted as a new character.

Verification
REQ-021 Keyboard path: kbd_data=7'h41 with kbd_rdy pulsed through a full 4-phase handshake, then read D010 -> DO=8'hC1; a following read of D011 -> bit7=0.
REQ-022 Keyboard back-pressure: with DEPTH=4, send 5 characters without any CPU reads -> 5th kbd_ack stays 0 until one D010 read, then the 5th character is accepted.
REQ-023 Display FIFO: write 8'h48 then 8'h49 to D012, responder acks each -> dsp_data sequence 7'h48, 7'h49; after the second ack, a D012 read returns 8'h00.
REQ-024 Display overflow: with dsp_ack held 0, write D012 DEPTH+2 times -> read of D012 returns {1, DEPTH}; read of D011 shows ovf=1; a second D011 read shows ovf=0.
REQ-025 Interrupt: write 8'h01 to D013 and deliver one character -> irq=1; read D010 -> irq=0 on the next cycle.
REQ-026 Reset: assert reset while dsp_rdy=1 with 3 entries queued -> dsp_rdy=0 immediately, and D012 reads 8'h00 after release.
